// File: rtl/asrv32_clint.sv
// Core-local interruptor for the ASRV32 hart.
// Provides the machine timer (mtime/mtimecmp) and the software-interrupt bit (msip)
// behind a Wishbone-classic slave, and mirrors every mtime update to the CSR unit.
module asrv32_clint #(
  parameter int CLK_FREQ_MHZ = 100
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [15:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [3:0]  i_wb_sel,
  output logic [31:0] o_wb_data,
  output logic        o_wb_ack,
  output logic [63:0] o_mtime,
  output logic        o_mtime_wr_en,
  output logic        o_timer_interrupt,
  output logic        o_software_interrupt
);

  localparam int            PW        = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ_MHZ - 1);

  localparam logic [15:0] ADDR_MSIP      = 16'h0000;
  localparam logic [15:0] ADDR_MTIMECMP0 = 16'h4000;
  localparam logic [15:0] ADDR_MTIMECMP1 = 16'h4004;
  localparam logic [15:0] ADDR_MTIME0    = 16'hBFF8;
  localparam logic [15:0] ADDR_MTIME1    = 16'hBFFC;

  logic [PW-1:0] presc;
  logic [63:0]   mtime;
  logic [63:0]   mtimecmp;
  logic          msip;

  logic          tick;
  logic          req;
  logic          wr;
  logic          any_lane;
  logic [15:0]   word_addr;
  logic          mtime_lo_wr;
  logic          mtime_hi_wr;
  logic          cmp_lo_wr;
  logic          cmp_hi_wr;
  logic          msip_wr;
  logic          mtime_changed;
  logic [63:0]   mtime_nxt;
  logic [63:0]   cmp_nxt;
  logic [31:0]   rd_mux;

  // Byte offsets are word-aligned; the two low address bits carry no information.
  logic unused_addr_bits;
  assign unused_addr_bits = ^i_wb_addr[1:0];

  // Replace only the byte lanes enabled by sel.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  lanes);
    logic [31:0] result;
    for (int b = 0; b < 4; b++) begin
      result[b*8 +: 8] = lanes[b] ? new_word[b*8 +: 8] : old_word[b*8 +: 8];
    end
    return result;
  endfunction

  assign tick      = (presc == PRESC_MAX);
  assign req       = i_wb_cyc & i_wb_stb & ~o_wb_ack;
  assign wr        = req & i_wb_we;
  assign any_lane  = |i_wb_sel;
  assign word_addr = {i_wb_addr[15:2], 2'b00};

  assign mtime_lo_wr   = wr & any_lane & (word_addr == ADDR_MTIME0);
  assign mtime_hi_wr   = wr & any_lane & (word_addr == ADDR_MTIME1);
  assign cmp_lo_wr     = wr & any_lane & (word_addr == ADDR_MTIMECMP0);
  assign cmp_hi_wr     = wr & any_lane & (word_addr == ADDR_MTIMECMP1);
  assign msip_wr       = wr & i_wb_sel[0] & (word_addr == ADDR_MSIP);
  assign mtime_changed = mtime_lo_wr | mtime_hi_wr | tick;

  // Next mtime: a bus write wins over the tick and merges into the pre-tick value.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    mtime_nxt = mtime;
    if (mtime_lo_wr) begin
      mtime_nxt[31:0] = merge_bytes(mtime[31:0], i_wb_data, i_wb_sel);
    end else if (mtime_hi_wr) begin
      mtime_nxt[63:32] = merge_bytes(mtime[63:32], i_wb_data, i_wb_sel);
    end else if (tick) begin
      mtime_nxt = mtime + 64'd1;
    end
  end

  // Next mtimecmp: word-wise byte-lane writes, no shadowing of the other half.
  always_comb begin
    cmp_nxt = mtimecmp;
    if (cmp_lo_wr) begin
      cmp_nxt[31:0] = merge_bytes(mtimecmp[31:0], i_wb_data, i_wb_sel);
    end else if (cmp_hi_wr) begin
      cmp_nxt[63:32] = merge_bytes(mtimecmp[63:32], i_wb_data, i_wb_sel);
    end
  end

  // Read multiplexer over the pre-write register state; unmapped offsets read 0.
  always_comb begin
    rd_mux = 32'h0;
    unique case (word_addr)
      ADDR_MSIP:      rd_mux = {31'h0, msip};
      ADDR_MTIMECMP0: rd_mux = mtimecmp[31:0];
      ADDR_MTIMECMP1: rd_mux = mtimecmp[63:32];
      ADDR_MTIME0:    rd_mux = mtime[31:0];
      ADDR_MTIME1:    rd_mux = mtime[63:32];
      default:        rd_mux = 32'h0;
    endcase
  end

  // Prescaler wraps every CLK_FREQ_MHZ cycles to give the 1 MHz tick.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    if (i_rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Timer and software-interrupt registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mtime    <= 64'h0;
      mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip     <= 1'b0;
    end else begin
      mtime    <= mtime_nxt;
      mtimecmp <= cmp_nxt;
      if (msip_wr) begin
        msip <= i_wb_data[0];
      end
    end
  end

  // Bus response: one-cycle ack with read data captured on the request edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_wb_ack  <= 1'b0;
      o_wb_data <= 32'h0;
    end else begin
      o_wb_ack  <= req;
      o_wb_data <= (req & ~i_wb_we) ? rd_mux : 32'h0;
    end
  end

  // Registered outputs toward the CSR unit, each one cycle behind the state it reports.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_mtime_wr_en        <= 1'b0;
      o_timer_interrupt    <= 1'b0;
      o_software_interrupt <= 1'b0;
    end else begin
      o_mtime_wr_en        <= mtime_changed;
      o_timer_interrupt    <= (mtime >= mtimecmp);
      o_software_interrupt <= msip;
    end
  end

  assign o_mtime = mtime;

endmodule

// File: tb/tb_asrv32_clint.sv
// Directed testbench for asrv32_clint with CLK_FREQ_MHZ = 4 (tick on every 4th edge).
module tb_asrv32_clint;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_cyc = 1'b0;
  logic        wb_stb = 1'b0;
  logic        wb_we = 1'b0;
  logic [15:0] wb_addr = 16'h0;
  logic [31:0] wb_wdata = 32'h0;
  logic [3:0]  wb_sel = 4'h0;
  logic [31:0] wb_rdata;
  logic        wb_ack;
  logic [63:0] mtime;
  logic        mtime_wr_en;
  logic        timer_irq;
  logic        sw_irq;

  int n_total = 0;
  int n_bad   = 0;
  int cnt;    // posedges since reset release; tick edges are cnt % 4 == 0

  asrv32_clint #(.CLK_FREQ_MHZ(4)) dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_wb_cyc             (wb_cyc),
    .i_wb_stb             (wb_stb),
    .i_wb_we              (wb_we),
    .i_wb_addr            (wb_addr),
    .i_wb_data            (wb_wdata),
    .i_wb_sel             (wb_sel),
    .o_wb_data            (wb_rdata),
    .o_wb_ack             (wb_ack),
    .o_mtime              (mtime),
    .o_mtime_wr_en        (mtime_wr_en),
    .o_timer_interrupt    (timer_irq),
    .o_software_interrupt (sw_irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cnt <= 0;
    else     cnt <= cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Called on a negedge: drives a request, returns at the next negedge with the response.
  task automatic bus_req(input logic we, input logic [15:0] addr, input logic [31:0] data,
                         input logic [3:0] sel, output logic ack, output logic [31:0] rdata);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
    wb_addr = addr; wb_wdata = data; wb_sel = sel;
    @(negedge clk);
    ack = wb_ack;
    rdata = wb_rdata;
  endtask

  task automatic bus_idle();
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_sel = 4'h0;
    @(negedge clk);
  endtask

  // Full access: two cycles, checks the ack pulse and, for reads, the data.
  task automatic bus_access(input string name, input logic we, input logic [15:0] addr,
                            input logic [31:0] data, input logic [3:0] sel,
                            input logic [31:0] exp);
    logic        ack;
    logic [31:0] rdata;
    bus_req(we, addr, data, sel, ack, rdata);
    check({name, "_ack"}, ack, 1);
    if (!we) check({name, "_data"}, rdata, exp);
    bus_idle();
    check({name, "_ack_drop"}, wb_ack, 0);
  endtask

  task automatic align(input int phase);
    for (int i = 0; i < 4 && (cnt % 4) != phase; i++) @(negedge clk);
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic        ack;
    logic [31:0] rdata;
    logic        found;

    vecs[0]  = '{1'b0, 16'h0000, 32'h0,         4'h0, 32'h0000_0001, "msip_rd"};
    vecs[1]  = '{1'b0, 16'h0002, 32'h0,         4'h0, 32'h0000_0001, "msip_rd_lowbits"};
    vecs[2]  = '{1'b1, 16'h4000, 32'h1234_5678, 4'h5, 32'h0,         "cmp_lo_wr_sel5"};
    vecs[3]  = '{1'b0, 16'h4000, 32'h0,         4'h0, 32'hFF34_FF78, "cmp_lo_rd"};
    vecs[4]  = '{1'b0, 16'h4004, 32'h0,         4'h0, 32'hFFFF_FFFF, "cmp_hi_rd"};
    vecs[5]  = '{1'b1, 16'h4004, 32'h0,         4'h0, 32'h0,         "cmp_hi_wr_sel0"};
    vecs[6]  = '{1'b0, 16'h4004, 32'h0,         4'h0, 32'hFFFF_FFFF, "cmp_hi_rd_nochg"};
    vecs[7]  = '{1'b1, 16'h4004, 32'hAABB_CCDD, 4'h8, 32'h0,         "cmp_hi_wr_sel8"};
    vecs[8]  = '{1'b0, 16'h4004, 32'h0,         4'h0, 32'hAAFF_FFFF, "cmp_hi_rd_b3"};
    vecs[9]  = '{1'b1, 16'h1234, 32'hDEAD_BEEF, 4'hF, 32'h0,         "unmapped_wr"};
    vecs[10] = '{1'b0, 16'h1234, 32'h0,         4'h0, 32'h0,         "unmapped_rd"};
    vecs[11] = '{1'b1, 16'h0000, 32'hFFFF_FFFE, 4'hF, 32'h0,         "msip_clr"};
    vecs[12] = '{1'b0, 16'h0000, 32'h0,         4'h0, 32'h0,         "msip_rd_clr"};

    // Reset state
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_ack", wb_ack, 0);
    check("rst_data", wb_rdata, 0);
    check("rst_mtime", mtime, 0);
    check("rst_wr_en", mtime_wr_en, 0);
    check("rst_tirq", timer_irq, 0);
    check("rst_sirq", sw_irq, 0);
    rst = 1'b0;

    // First reads after reset
    bus_access("rd_mtime_lo_rst", 1'b0, 16'hBFF8, 32'h0, 4'h0, 32'h0);
    bus_access("rd_cmp_hi_rst", 1'b0, 16'h4004, 32'h0, 4'h0, 32'hFFFF_FFFF);
    check("tirq_after_rst", timer_irq, 0);

    // msip write with one-cycle interrupt latency
    bus_req(1'b1, 16'h0000, 32'h3, 4'hF, ack, rdata);
    check("msip_wr_ack", ack, 1);
    check("sirq_not_yet", sw_irq, 0);
    bus_idle();
    check("sirq_set", sw_irq, 1);

    // Table of register accesses
    for (int i = 0; i < 13; i++) begin
      bus_access(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].sel, vecs[i].exp);
    end
    check("sirq_cleared", sw_irq, 0);
    check("tirq_still_low", timer_irq, 0);

    // Held strobe: ack every other cycle
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 16'h4004;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("b2b_ack_%0d", i), wb_ack, (i % 2 == 0) ? 1'b1 : 1'b0);
      if (i == 0) check("b2b_data", wb_rdata, 32'hAAFF_FFFF);
    end
    bus_idle();

    // Reset in the middle of a transaction
    bus_access("msip_set_again", 1'b1, 16'h0000, 32'h1, 4'h1, 32'h0);
    bus_req(1'b0, 16'hBFF8, 32'h0, 4'h0, ack, rdata);
    check("mid_ack_pending", ack, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_ack", wb_ack, 0);
    check("mid_rst_mtime", mtime, 0);
    check("mid_rst_sirq", sw_irq, 0);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle 40 cycles: wr_en pulses on every 4th edge, mtime ends at 10
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      check($sformatf("idle_wr_en_%0d", k), mtime_wr_en, (k % 4 == 0) ? 1'b1 : 1'b0);
    end
    check("idle_mtime_40", mtime, 64'd10);
    bus_access("rd_cmp_lo_after_rst", 1'b0, 16'h4000, 32'h0, 4'h0, 32'hFFFF_FFFF);
    bus_access("rd_msip_after_rst", 1'b0, 16'h0000, 32'h0, 4'h0, 32'h0);

    // Carry: low word all ones written the cycle before a tick
    bus_access("wr_mtime_hi0", 1'b1, 16'hBFFC, 32'h0, 4'hF, 32'h0);
    align(2);
    bus_access("wr_mtime_lo_ff", 1'b1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF, 32'h0);
    check("carry_mtime", mtime, 64'h0000_0001_0000_0000);
    check("carry_wr_en", mtime_wr_en, 1);
    bus_access("rd_mtime_hi_carry", 1'b0, 16'hBFFC, 32'h0, 4'h0, 32'h1);
    bus_access("rd_mtime_lo_carry", 1'b0, 16'hBFF8, 32'h0, 4'h0, 32'h0);

    // Timer interrupt: compare at 20, then raise the compare to 100
    bus_access("wr_mtime_hi_clr", 1'b1, 16'hBFFC, 32'h0, 4'hF, 32'h0);
    bus_access("wr_cmp_hi0", 1'b1, 16'h4004, 32'h0, 4'hF, 32'h0);
    bus_access("wr_cmp_lo20", 1'b1, 16'h4000, 32'd20, 4'hF, 32'h0);
    check("tirq_below_cmp", timer_irq, 0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (mtime == 64'd20) found = 1'b1;
    end
    check("mtime_reach_20", found, 1);
    check("tirq_lag", timer_irq, 0);
    @(negedge clk);
    check("tirq_rise", timer_irq, 1);
    repeat (3) @(negedge clk);
    check("tirq_level", timer_irq, 1);
    bus_req(1'b1, 16'h4000, 32'd100, 4'hF, ack, rdata);
    check("cmp100_ack", ack, 1);
    check("tirq_before_fall", timer_irq, 1);
    bus_idle();
    check("tirq_fall", timer_irq, 0);

    // Byte-lane mtime write landing on a tick edge
    align(0);
    bus_access("wr_mtime_lo_known", 1'b1, 16'hBFF8, 32'h1122_3344, 4'hF, 32'h0);
    @(negedge clk);
    bus_access("wr_mtime_b1_tick", 1'b1, 16'hBFF8, 32'h0000_AB00, 4'h2, 32'h0);
    check("lane_tick_mtime", mtime, 64'h0000_0000_1122_AB44);
    bus_access("rd_mtime_lo_lane", 1'b0, 16'hBFF8, 32'h0, 4'h0, 32'h1122_AB44);
    bus_access("rd_unmapped_end", 1'b0, 16'h1234, 32'h0, 4'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
